// File: rtl/serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit operands LSB-first, one bit per clock,
// using a single full-adder cell and a carry flop. Start/done handshake; the
// registered result holds until the next accepted operation completes.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    // Holds the WIDTH-1 sum bits produced so far; the final bit comes straight
    // from the adder cell on the completing edge.
    logic [WIDTH-2:0] sh_s;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             accept;
    logic             last;
    logic             s;
    logic             carry_nxt;
    logic [WIDTH-1:0] sum_cat;

    // Full-adder cell, acceptance and completion decode
    always_comb begin
        accept    = start && ((state == ST_IDLE) || (state == ST_DONE));
        last      = (state == ST_RUN) && (cnt == LAST_BIT);
        s         = sh_a[0] ^ sh_b[0] ^ carry;
        carry_nxt = (sh_a[0] & sh_b[0]) | (sh_a[0] & carry) | (sh_b[0] & carry);
        sum_cat   = {s, sh_s};
    end

    // Control FSM: IDLE -> RUN (WIDTH cycles) -> DONE (one cycle)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (start) state <= ST_RUN;
                ST_RUN:  if (last) state <= ST_DONE;
                ST_DONE: state <= start ? ST_RUN : ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Operand shift registers, carry flop, partial sum and bit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_a  <= '0;
            sh_b  <= '0;
            sh_s  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (accept) begin
            sh_a  <= A;
            sh_b  <= B;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (state == ST_RUN) begin
            sh_a  <= {1'b0, sh_a[WIDTH-1:1]};
            sh_b  <= {1'b0, sh_b[WIDTH-1:1]};
            sh_s  <= sum_cat[WIDTH-1:1];
            carry <= carry_nxt;
            cnt   <= cnt + CW'(1);
        end
    end

    // Result registers: updated only on the edge that processes the last bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Sum  <= '0;
            Cout <= 1'b0;
        end else if (last) begin
            Sum  <= sum_cat;
            Cout <= carry_nxt;
        end
    end

    // Status outputs decode directly from the state register
    always_comb begin
        busy = (state == ST_RUN);
        done = (state == ST_DONE);
    end

endmodule
